fraction_reduce: RTL and testbench
==================================

// Module: fraction_reduce
// PURPOSE
//  Downstream consumer of the GCD stage. Takes a numerator/denominator pair plus
//  their GCD and emits the reduced fraction (in0/g, in1/g).
//  Two sequential restoring dividers run in lockstep, each WIDTH iterations long.
//  Uses the same valid/ready sync convention as the GCD stage, so it chains behind
//  it directly. Its pair inputs are tapped from the same source that feeds the GCD.
// PARAMETERS
//  WIDTH  `intN (8)  unsigned operand/result width in bits
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  rst        in   1      reset: synchronous, active-high
//  in_valid   in   1      upstream presents in0/in1/in2
//  in_ready   out  1      block can accept an input this cycle
//  in0        in   WIDTH  numerator (unsigned)
//  in1        in   WIDTH  denominator (unsigned)
//  in2        in   WIDTH  gcd(in0,in1) from the GCD stage (unsigned)
//  out_valid  out  1      out0/out1/out_err are valid
//  out_ready  in   1      downstream accepts the result
//  out0       out  WIDTH  in0 / in2 (quotient)
//  out1       out  WIDTH  in1 / in2 (quotient)
//  out_err    out  1      error flag for this result
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; out_valid=0; out0=out1=0; out_err=0;
//    iteration counter=0. Reset wins over every other event, including mid-division
//    and a pending output; the in-flight operation is discarded.
//  - FSM:
//    IDLE -> DIV  on accept with in2!=0
//    IDLE -> DONE on accept with in2==0
//    DIV  -> DONE after WIDTH iteration edges
//    DONE -> IDLE on out_valid & out_ready without a new accept
//    DONE -> DIV or DONE on a same-cycle accept, chosen by in2 as from IDLE
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from
//    out_ready, which gives back-to-back throughput. An accept is in_valid & in_ready.
//  - On accept, operands are registered and the counter is cleared. Input ports are
//    don't-care after the accept edge. in_valid while busy is ignored, not queued.
//  - DIV: each edge shifts one dividend MSB into a (WIDTH+1)-bit partial remainder.
//    The divisor is subtracted if it fits, and the quotient bit is set. Both dividers
//    share the divisor in2.
//  - Latency: out_valid rises exactly WIDTH cycles after the accept edge (8 for
//    WIDTH=8). For in2==0 it rises 1 cycle after the accept edge.
//  - out_valid=1 only in DONE. out0/out1/out_err are held stable while
//    out_valid & !out_ready (backpressure). They keep their last values in IDLE.
//  - Zero divisor (in2==0): out0=out1=0, out_err=1, no iterations.
//  - No truncation. Quotient <= dividend, so it always fits in WIDTH bits.
//  - All-zero numerator with in2!=0 gives out0=0 normally.
// CONFIGURATION
//  FRACTION_REDUCE_REM_CHECK_EN
//    defined:   final remainders are checked. out_err=1 if either remainder is
//               nonzero (in2 is not a common divisor) or in2==0. Quotients are still
//               output (floor).
//    undefined: remainders are discarded; out_err=1 only for in2==0. No remainder
//               compare logic is generated.
// TESTING
//  1. in0=21,in1=35,in2=7 -> out0=3,out1=5,out_err=0; out_valid exactly 8 cycles
//     after the accept edge.
//  2. in0=0,in1=0,in2=0 -> out0=0,out1=0,out_err=1; out_valid 1 cycle after accept.
//  3. in0=255,in1=255,in2=255 -> out0=1,out1=1,out_err=0. Then (12,18,6) ->
//     (2,3,0), offered with in_valid=1 during the DONE cycle with out_ready=1:
//     accepted same cycle, no idle gap.
//  4. Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable,
//     in_ready=0, a new in_valid is ignored. out_ready=1 -> one transfer, then IDLE.
//  5. Reset: rst=1 at iteration 4 of (21,35,7) -> next cycle out_valid=0, out0=out1=0,
//     in_ready=1. A fresh (21,35,7) then completes normally as (3,5).
//  6. (10,15,4) -> out0=2,out1=3. out_err=1 with FRACTION_REDUCE_REM_CHECK_EN
//     defined; out_err=0 without it.

Source files
------------

// File: rtl/fraction_reduce.sv
// fraction_reduce: reduces in0/in1 by their GCD in2 using two lockstep restoring dividers.
// Define FRACTION_REDUCE_REM_CHECK_EN to flag results whose remainders are nonzero.
module fraction_reduce #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic             out_err
);
   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 2);

   typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] dvd0_q, dvd0_d, dvd1_q, dvd1_d;
   logic [WIDTH-1:0] rem0_q, rem0_d, rem1_q, rem1_d;
   logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
   logic             err_q, err_d;
   logic             accept;
   logic [WIDTH-1:0] s_div, s_dvd0, s_dvd1, s_rem0, s_rem1;
   logic [WIDTH-1:0] n_dvd0, n_dvd1, n_rem0, n_rem1;

   // One restoring step: the (WIDTH+1)-bit trial remainder takes the dividend MSB, the
   // divisor is subtracted if it fits, and the quotient bit fills the freed dividend LSB.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                   input logic [WIDTH-1:0] dvd,
                                                   input logic [WIDTH-1:0] div);
      logic [WIDTH:0] trial;
      logic           fit;
      trial = {rem, dvd[WIDTH-1]};
      fit   = (trial >= {1'b0, div});
      return {fit ? (trial[WIDTH-1:0] - div) : trial[WIDTH-1:0], dvd[WIDTH-2:0], fit};
   endfunction

   // The accept edge performs the first iteration straight from the input ports.
   always_comb begin
      if (state_q == StDiv) begin
         s_rem0 = rem0_q;
         s_rem1 = rem1_q;
         s_dvd0 = dvd0_q;
         s_dvd1 = dvd1_q;
         s_div  = div_q;
      end else begin
         s_rem0 = '0;
         s_rem1 = '0;
         s_dvd0 = in0;
         s_dvd1 = in1;
         s_div  = in2;
      end
      {n_rem0, n_dvd0} = div_step(s_rem0, s_dvd0, s_div);
      {n_rem1, n_dvd1} = div_step(s_rem1, s_dvd1, s_div);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         div_q   <= '0;
         dvd0_q  <= '0;
         dvd1_q  <= '0;
         rem0_q  <= '0;
         rem1_q  <= '0;
         out0_q  <= '0;
         out1_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         dvd0_q  <= dvd0_d;
         dvd1_q  <= dvd1_d;
         rem0_q  <= rem0_d;
         rem1_q  <= rem1_d;
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      dvd0_d  = dvd0_q;
      dvd1_d  = dvd1_q;
      rem0_d  = rem0_q;
      rem1_d  = rem1_q;
      out0_d  = out0_q;
      out1_d  = out1_q;
      err_d   = err_q;
      if (accept) begin
         cnt_d = '0;
         div_d = in2;
         if (in2 == '0) begin
            state_d = StDone;
            out0_d  = '0;
            out1_d  = '0;
            err_d   = 1'b1;
         end else begin
            state_d = StDiv;
            rem0_d  = n_rem0;
            rem1_d  = n_rem1;
            dvd0_d  = n_dvd0;
            dvd1_d  = n_dvd1;
         end
      end else begin
         case (state_q)
            StDiv: begin
               rem0_d = n_rem0;
               rem1_d = n_rem1;
               dvd0_d = n_dvd0;
               dvd1_d = n_dvd1;
               if (cnt_q == LastCnt) begin
                  state_d = StDone;
                  out0_d  = n_dvd0;
                  out1_d  = n_dvd1;
`ifdef FRACTION_REDUCE_REM_CHECK_EN
                  err_d   = (n_rem0 != '0) || (n_rem1 != '0);
`else
                  err_d   = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) state_d = StIdle;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
      out_valid = (state_q == StDone);
   end

   assign accept  = in_valid & in_ready;
   assign out0    = out0_q;
   assign out1    = out1_q;
   assign out_err = err_q;

endmodule

// File: tb/tb_fraction_reduce.sv
// tb_fraction_reduce: directed bench for fraction_reduce with a queue of expected results.
// Honours FRACTION_REDUCE_REM_CHECK_EN when forming the expected error flag.
module tb_fraction_reduce;
   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] o0;
      logic [W-1:0] o1;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in0, in1, in2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out0, out1;
   logic         out_err;

   int   cyc = 0;
   int   acc_cyc = 0;
   int   passed = 0;
   int   failed = 0;
   int   total = 0;
   exp_t sb[$];
   exp_t last_e;

   fraction_reduce #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .out1      (out1),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g);
      exp_t e;
      int   n;
      in_valid = 1'b1;
      in0 = a;
      in1 = b;
      in2 = g;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_ready", in_ready, 1);
      if (g == '0) begin
         e = '{o0: '0, o1: '0, err: 1'b1};
      end else begin
         e.o0 = a / g;
         e.o1 = b / g;
`ifdef FRACTION_REDUCE_REM_CHECK_EN
         e.err = ((a % g) != 0) || ((b % g) != 0);
`else
         e.err = 1'b0;
`endif
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Latency = edges from the accept edge through the first edge that samples out_valid high.
   task automatic wait_out(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_latency"}, cyc - acc_cyc + 1, exp_lat);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, sb.size(), 1);
      end else begin
         last_e = sb.pop_front();
         check({tag, "_out0"}, out0, last_e.o0);
         check({tag, "_out1"}, out1, last_e.o1);
         check({tag, "_err"}, out_err, last_e.err);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in0 = '0;
      in1 = '0;
      in2 = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_out0", out0, 0);
      check("rst_out1", out1, 0);
      check("rst_err", out_err, 0);
      check("rst_ready", in_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      send(21, 35, 7);
      wait_out("t1", 8);
      @(negedge clk);
      check("t1_idle_valid", out_valid, 0);
      check("t1_idle_ready", in_ready, 1);

      send(0, 0, 0);
      wait_out("t2", 1);
      @(negedge clk);

      // Next operand offered in the DONE cycle with out_ready high.
      send(255, 255, 255);
      wait_out("t3a", 8);
      check("t3_done_ready", in_ready, 1);
      send(12, 18, 6);
      check("t3_nogap_busy", in_ready, 0);
      wait_out("t3b", 8);
      @(negedge clk);

      out_ready = 1'b0;
      send(21, 35, 7);
      wait_out("t4", 8);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in0 = 100;
         in1 = 50;
         in2 = 25;
         check("t4_hold_valid", out_valid, 1);
         check("t4_hold_ready", in_ready, 0);
         check("t4_hold_out0", out0, last_e.o0);
         check("t4_hold_out1", out1, last_e.o1);
         check("t4_hold_err", out_err, last_e.err);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_xfer_valid", out_valid, 0);
      check("t4_xfer_ready", in_ready, 1);
      @(negedge clk);
      check("t4_no_queue", out_valid, 0);

      // Reset lands on the edge of the fourth iteration.
      send(21, 35, 7);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_valid", out_valid, 0);
      check("t5_out0", out0, 0);
      check("t5_out1", out1, 0);
      check("t5_ready", in_ready, 1);
      rst = 1'b0;
      void'(sb.pop_back());
      @(negedge clk);
      send(21, 35, 7);
      wait_out("t5", 8);
      @(negedge clk);

      send(10, 15, 4);
      wait_out("t6", 8);
      @(negedge clk);

      send(0, 9, 3);
      wait_out("zero_num", 8);
      @(negedge clk);
      send(200, 7, 1);
      wait_out("unit_div", 8);
      @(negedge clk);
      send(255, 15, 5);
      wait_out("max_num", 8);
      @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
